// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM and its datapath:
// state enum, opcodes, mux selects, ALU ops, trap causes and the opcode dispatch.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH,
        S_DECODE,
        S_EX_R,
        S_EX_I,
        S_WB_ALU,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_JALR_EX,
        S_JALR_WB,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    localparam logic [1:0] A_PC      = 2'b00;
    localparam logic [1:0] A_RS1     = 2'b01;
    localparam logic [1:0] A_OLDPC   = 2'b10;
    localparam logic [1:0] A_ZERO    = 2'b11;

    localparam logic [1:0] B_RS2     = 2'b00;
    localparam logic [1:0] B_FOUR    = 2'b01;
    localparam logic [1:0] B_IMM     = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_CMP    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;

    // Dispatch target out of DECODE; S_TRAP marks an illegal instruction.
    function automatic state_t decode_op(input logic [6:0] op, input logic [2:0] funct3,
                                         input logic [6:0] funct7);
        case (op)
            OP_R:      return (funct7 == F7_BASE || funct7 == F7_ALT || funct7 == F7_MULDIV)
                              ? S_EX_R : S_TRAP;
            OP_I:      return S_EX_I;
            OP_LOAD:   return S_ADDR;
            OP_STORE:  return S_ADDR;
            OP_BRANCH: return (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_BRANCH : S_TRAP;
            OP_JAL:    return S_JAL;
            OP_JALR:   return S_JALR_EX;
            OP_LUI:    return S_LUI;
            OP_AUIPC:  return S_AUIPC;
            default:   return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_mem_wait.sv
// Memory wait-state counter: counts cycles a request is pending without ready
// and flags when the count reaches MEM_TIMEOUT (0 disables the timeout).
module mc_mem_wait #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic req,
    input  logic ready,
    output logic timeout_hit
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt <= '0;
        end else if (req && !ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        timeout_hit = (MEM_TIMEOUT != 0) && req && !ready && (cnt == TO_W'(MEM_TIMEOUT));
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM with memory handshake, timeout/illegal trap and retire strobe.
// Optional perf counters (cyc_cnt, ret_cnt) are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             i_or_d,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             branch,
    output logic             branch_n,
    output logic             retire,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [4:0]       state_o
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    if (CNT_W == 0 || (MEM_TIMEOUT >> TO_W) != 0) begin : g_bad_cfg
        $error("mc_ctrl_fsm: CNT_W must be nonzero and MEM_TIMEOUT < 2**TO_W");
    end

    state_t state;
    state_t dec_nx;
    logic   timeout_hit;
    logic   wait_start;

    // Clearing whenever no request is pending or one completes leaves the
    // counter at zero on every entry into FETCH, MEM_RD or MEM_WR.
    always_comb begin
        wait_start = !mem_req || mem_ready;
        dec_nx     = decode_op(op, funct3, funct7);
    end

    mc_mem_wait #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_wait (
        .clk        (clk),
        .reset      (reset),
        .start      (wait_start),
        .req        (mem_req),
        .ready      (mem_ready),
        .timeout_hit(timeout_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            trap_cause <= CAUSE_NONE;
        end else begin
            case (state)
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (timeout_hit) begin
                        state      <= S_TRAP;
                        trap_cause <= CAUSE_MEM_TO;
                    end else if (mem_ready) begin
                        state <= (state == S_FETCH)  ? S_DECODE :
                                 (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                    end
                end
                S_DECODE: begin
                    state <= dec_nx;
                    if (dec_nx == S_TRAP) trap_cause <= CAUSE_ILLEGAL;
                end
                S_EX_R, S_EX_I: state <= S_WB_ALU;
                S_ADDR:         state <= (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
                S_JALR_EX:      state <= S_JALR_WB;
                S_TRAP:         state <= S_TRAP;
                default:        state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = WB_ALUOUT;
        reg_write  = 1'b0;
        alu_src_a  = A_PC;
        alu_src_b  = B_RS2;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        branch     = 1'b0;
        branch_n   = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        state_o    = state;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = A_OLDPC;
                alu_src_b = B_IMM;
            end
            S_EX_R: begin
                alu_src_a = A_RS1;
                alu_op    = ALU_RFUNCT;
            end
            S_EX_I: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                alu_op    = ALU_IFUNCT;
            end
            S_ADDR, S_JALR_EX: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            S_WB_ALU, S_AUIPC, S_WB_MEM, S_LUI: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                mem_to_reg = (state == S_WB_MEM) ? WB_MDR :
                             (state == S_LUI)    ? WB_IMM : WB_ALUOUT;
            end
            S_BRANCH: begin
                alu_src_a = A_RS1;
                alu_op    = ALU_CMP;
                pc_src    = PC_ALUOUT;
                branch    = (funct3 == F3_BEQ);
                branch_n  = (funct3 == F3_BNE);
                retire    = 1'b1;
            end
            S_JAL, S_JALR_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_PC4;
                pc_write   = 1'b1;
                pc_src     = PC_ALUOUT;
                retire     = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state != S_TRAP) cyc_cnt <= cyc_cnt + 1'b1;
            if (retire)          ret_cnt <= ret_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction cycle model built into a queue, compared every cycle.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pc_write, i_or_d, mem_write, ir_write, reg_write;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, trap_cause;
    logic       branch, branch_n, retire, trap;
    logic [4:0] state_o;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
    logic [31:0] ret_base;
`endif

    mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .TO_W(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .branch(branch), .branch_n(branch_n),
        .retire(retire), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
`ifdef MC_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, pc_write, i_or_d, mem_write, ir_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src;
        logic       branch, branch_n, retire, trap;
        logic [1:0] trap_cause;
    } ctl_t;

    typedef struct {
        logic   rdy;
        ctl_t   ctl;
        state_t st;
    } cyc_t;

    cyc_t       q[$];
    logic [1:0] m_cause = 2'b00;
    int         n_cmp = 0;
    int         n_bad = 0;
    ctl_t       act;

    assign act = {mem_req, pc_write, i_or_d, mem_write, ir_write, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, branch, branch_n, retire, trap,
                  trap_cause};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
        end
    endtask

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.trap_cause = m_cause;
        return c;
    endfunction

    task automatic push(input logic rdy, input ctl_t c, input state_t s);
        cyc_t e;
        e.rdy = rdy;
        e.ctl = c;
        e.st  = s;
        q.push_back(e);
    endtask

    // Ready is also driven high in non-request cycles: it must be ignored there.
    task automatic m_trap(input logic [1:0] cause);
        ctl_t c;
        m_cause = cause;
        for (int i = 0; i < 3; i++) begin
            c = idle();
            c.trap = 1'b1;
            push(1'b1, c, S_TRAP);
        end
    endtask

    task automatic m_mem(input state_t s, input ctl_t base, input ctl_t done,
                         input int wait_n, output bit ok);
        int n = (wait_n > TMO) ? TMO + 1 : wait_n;
        for (int i = 0; i < n; i++) push(1'b0, base, s);
        if (wait_n > TMO) begin
            m_trap(CAUSE_MEM_TO);
            ok = 1'b0;
        end else begin
            push(1'b1, ctl_t'(base | done), s);
            ok = 1'b1;
        end
    endtask

    task automatic push_wb(input state_t s, input logic [1:0] sel);
        ctl_t c = idle();
        c.reg_write  = 1'b1;
        c.mem_to_reg = sel;
        c.retire     = 1'b1;
        push(1'b1, c, s);
    endtask

    task automatic push_link(input state_t s);
        ctl_t c = idle();
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b10;
        c.pc_write   = 1'b1;
        c.pc_src     = 2'b01;
        c.retire     = 1'b1;
        push(1'b1, c, s);
    endtask

    task automatic m_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw);
        ctl_t c, x;
        bit   ok;
        c = idle(); c.mem_req = 1'b1; c.alu_src_b = 2'b01;
        x = '0; x.ir_write = 1'b1; x.pc_write = 1'b1;
        m_mem(S_FETCH, c, x, fw, ok);
        if (!ok) return;
        c = idle(); c.alu_src_a = 2'b10; c.alu_src_b = 2'b10;
        push(1'b1, c, S_DECODE);
        case (o)
            7'b0110011: begin
                if (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) begin
                    c = idle(); c.alu_src_a = 2'b01; c.alu_op = 2'b10;
                    push(1'b1, c, S_EX_R);
                    push_wb(S_WB_ALU, 2'b00);
                end else m_trap(CAUSE_ILLEGAL);
            end
            7'b0010011: begin
                c = idle(); c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b11;
                push(1'b1, c, S_EX_I);
                push_wb(S_WB_ALU, 2'b00);
            end
            7'b0000011, 7'b0100011: begin
                c = idle(); c.alu_src_a = 2'b01; c.alu_src_b = 2'b10;
                push(1'b1, c, S_ADDR);
                c = idle(); c.mem_req = 1'b1; c.i_or_d = 1'b1;
                x = '0;
                if (o == 7'b0100011) begin
                    c.mem_write = 1'b1;
                    x.retire = 1'b1;
                    m_mem(S_MEM_WR, c, x, mw, ok);
                end else begin
                    m_mem(S_MEM_RD, c, x, mw, ok);
                    if (ok) push_wb(S_WB_MEM, 2'b01);
                end
            end
            7'b1100011: begin
                if (f3 == 3'd0 || f3 == 3'd1) begin
                    c = idle(); c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_src = 2'b01;
                    c.branch = (f3 == 3'd0); c.branch_n = (f3 == 3'd1); c.retire = 1'b1;
                    push(1'b1, c, S_BRANCH);
                end else m_trap(CAUSE_ILLEGAL);
            end
            7'b1101111: push_link(S_JAL);
            7'b1100111: begin
                c = idle(); c.alu_src_a = 2'b01; c.alu_src_b = 2'b10;
                push(1'b1, c, S_JALR_EX);
                push_link(S_JALR_WB);
            end
            7'b0110111: push_wb(S_LUI, 2'b11);
            7'b0010111: push_wb(S_AUIPC, 2'b00);
            default:    m_trap(CAUSE_ILLEGAL);
        endcase
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            chk("ctl", 32'(act), 32'(q[0].ctl));
            chk("state", 32'(state_o), 32'(q[0].st));
            void'(q.pop_front());
        end
    end

    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input int fw, input int mw);
        op = o; funct3 = f3; funct7 = f7;
        m_instr(o, f3, f7, fw, mw);
    endtask

    task automatic run_q();
        int guard = 0;
        while (q.size() > 0 && guard < 200) begin
            mem_ready = q[0].rdy;
            @(posedge clk); #1;
            guard++;
        end
        mem_ready = 1'b0;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input int fw, input int mw);
        build(o, f3, f7, fw, mw);
        run_q();
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_cause = 2'b00;
        chk("rst_state", 32'(state_o), 32'(S_FETCH));
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd1);
`ifdef MC_CTRL_PERF_EN
        chk("rst_cyc_cnt", cyc_cnt, 32'd0);
        chk("rst_ret_cnt", ret_cnt, 32'd0);
`endif
    endtask

    function automatic int count_state(input state_t s);
        int n = 0;
        foreach (q[i]) if (q[i].st == s) n++;
        return n;
    endfunction

    initial begin
        do_reset();

        build(7'b0110011, 3'd0, 7'h00, 0, 0);
        chk("add_len", q.size(), 32'd4);
        chk("add_retire4", 32'(q[3].ctl.retire), 32'd1);
        chk("add_retire3", 32'(q[2].ctl.retire), 32'd0);
        run_q();

        instr(7'b0110011, 3'd0, 7'h20, 2, 0);
        instr(7'b0010011, 3'd0, 7'h00, 0, 0);

        build(7'b0000011, 3'd2, 7'h00, 0, 3);
        chk("lw_len", q.size(), 32'd8);
        chk("lw_memrd_cyc", count_state(S_MEM_RD), 32'd4);
        chk("lw_wb_sel", 32'(q[7].ctl.mem_to_reg), 32'd1);
        run_q();

        instr(7'b0100011, 3'd2, 7'h00, 1, 2);
        instr(7'b1100011, 3'd0, 7'h00, 0, 0);
        build(7'b1100011, 3'd1, 7'h00, 0, 0);
        chk("bne_len", q.size(), 32'd3);
        chk("bne_flag", 32'(q[2].ctl.branch_n), 32'd1);
        run_q();
        instr(7'b0110111, 3'd0, 7'h00, 0, 0);
        instr(7'b0010111, 3'd0, 7'h00, 0, 0);

`ifdef MC_CTRL_PERF_EN
        ret_base = ret_cnt;
`endif
        build(7'b1101111, 3'd0, 7'h00, 0, 0);
        chk("jal_len", q.size(), 32'd3);
        run_q();
        build(7'b1100111, 3'd0, 7'h00, 0, 0);
        chk("jalr_len", q.size(), 32'd4);
        run_q();
`ifdef MC_CTRL_PERF_EN
        chk("ret_cnt_delta", ret_cnt - ret_base, 32'd2);
`endif

        // Ready arrives on the very cycle the counter reaches the limit.
        build(7'b0110011, 3'd0, 7'h01, TMO, 0);
        chk("edge_no_trap", count_state(S_TRAP), 32'd0);
        run_q();

        build(7'b0110011, 3'd0, 7'h00, 100, 0);
        chk("to_fetch_cyc", count_state(S_FETCH), 32'd17);
        run_q();
        chk("to_cause", 32'(trap_cause), 32'd2);
        do_reset();

        instr(7'b1100011, 3'd4, 7'h00, 0, 0);
        chk("br_ill_cause", 32'(trap_cause), 32'd1);
        do_reset();

        instr(7'b0000000, 3'd0, 7'h00, 0, 0);
        do_reset();
        instr(7'b0110011, 3'd0, 7'h02, 0, 0);
        do_reset();
        instr(7'b0000011, 3'd2, 7'h00, 0, 100);
        do_reset();
        instr(7'b0010011, 3'd0, 7'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
